multi_debounce: RTL and testbench

MULTI_DEBOUNCE -- requirements
Module: multi_debounce

---
 rtl/multi_debounce_pkg.sv | 11 +
 rtl/multi_debounce_if.sv | 36 +++
 rtl/multi_debounce_ch.sv | 87 ++++++++
 rtl/multi_debounce.sv | 47 ++++
 tb/tb_multi_debounce.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/multi_debounce_pkg.sv
// Shared defaults for the multi-channel key debouncer.
// Contents: default counter widths and thresholds, used by the top level
// and by the per-channel debouncer when no override is given.
package debounce_pkg;

  localparam int unsigned       DEF_CNT_W    = 24;
  localparam logic [23:0]       DEF_CNT_MAX  = 24'd10_000_000;
  localparam int unsigned       DEF_LONG_W   = 16;
  localparam logic [15:0]       DEF_LONG_MAX = 16'd50_000;

endpackage

// File: rtl/multi_debounce_if.sv
// Key bus for multi_debounce.
// Signals (N_CH bits each):
//   key_i  - raw asynchronous key levels
//   key_o  - debounced registered levels
//   rise_o - one-cycle pulse on key_o 0->1
//   fall_o - one-cycle pulse on key_o 1->0
//   long_o - one-cycle pulse once a key has been held LONG_MAX clocks
// master: the side that supplies keys and consumes events.
// slave : the debouncer.
interface multi_debounce_if #(
  parameter int unsigned N_CH = 4
);

  logic [N_CH-1:0] key_i;
  logic [N_CH-1:0] key_o;
  logic [N_CH-1:0] rise_o;
  logic [N_CH-1:0] fall_o;
  logic [N_CH-1:0] long_o;

  modport master (
    output key_i,
    input  key_o,
    input  rise_o,
    input  fall_o,
    input  long_o
  );

  modport slave (
    input  key_i,
    output key_o,
    output rise_o,
    output fall_o,
    output long_o
  );

endinterface

// File: rtl/multi_debounce_ch.sv
// Single-channel key debouncer: two-flop synchroniser, stability counter,
// registered edge pulses and long-press detection.
// Ports:
//   clk, rst - clock, synchronous active-high reset
//   key_i    - raw asynchronous key level
//   key_o    - debounced level
//   rise_o   - one-cycle pulse in the first cycle key_o shows 1
//   fall_o   - one-cycle pulse in the first cycle key_o shows 0
//   long_o   - one-cycle pulse when key_o has been 1 for LONG_MAX clocks
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int unsigned       CNT_W    = DEF_CNT_W,
  parameter logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEF_CNT_MAX),
  parameter int unsigned       LONG_W   = DEF_LONG_W,
  parameter logic [LONG_W-1:0] LONG_MAX = LONG_W'(DEF_LONG_MAX)
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic key_o,
  output logic rise_o,
  output logic fall_o,
  output logic long_o
);

  logic              s1;
  logic              s2;
  logic              cand;
  logic [CNT_W-1:0]  cnt;
  logic [LONG_W-1:0] hcnt;
  logic              key_nxt;
  logic              long_hit;

  // Next debounced level is computed combinationally so that the edge
  // pulses and the long-press counter line up with the cycle in which
  // key_o itself changes.
  always_comb begin
    key_nxt = key_o;
    if ((s2 == cand) && (cnt == CNT_MAX)) begin
      key_nxt = cand;
    end
  end

  // hcnt only advances on clocks where key_o was already 1, so the pulse
  // lands LONG_MAX clocks after rise_o; a release in the same edge wins.
  always_comb begin
    long_hit = key_o && key_nxt && (hcnt == (LONG_MAX - LONG_W'(1)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      cand   <= 1'b0;
      cnt    <= '0;
      key_o  <= 1'b0;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
      hcnt   <= '0;
      long_o <= 1'b0;
    end else begin
      s1 <= key_i;
      s2 <= s1;

      if (s2 != cand) begin
        cand <= s2;
        cnt  <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end

      key_o  <= key_nxt;
      rise_o <= key_nxt & ~key_o;
      fall_o <= ~key_nxt & key_o;

      if (!key_nxt) begin
        hcnt <= '0;
      end else if (key_o && (hcnt != LONG_MAX)) begin
        hcnt <= hcnt + LONG_W'(1);
      end

      long_o <= long_hit;
    end
  end

endmodule

// File: rtl/multi_debounce.sv
// Multi-channel key debouncer: N_CH independent debounce_ch instances.
// Ports:
//   clk, rst - clock, synchronous active-high reset
//   bus      - multi_debounce_if.slave (key_i in; key_o, rise_o, fall_o,
//              long_o out, one bit per channel)
module multi_debounce
  import debounce_pkg::*;
#(
  parameter int unsigned       N_CH     = 4,
  parameter int unsigned       CNT_W    = DEF_CNT_W,
  parameter logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEF_CNT_MAX),
  parameter int unsigned       LONG_W   = DEF_LONG_W,
  parameter logic [LONG_W-1:0] LONG_MAX = LONG_W'(DEF_LONG_MAX)
) (
  input  logic            clk,
  input  logic            rst,
  multi_debounce_if.slave bus
);

  logic [N_CH-1:0] key_w;
  logic [N_CH-1:0] rise_w;
  logic [N_CH-1:0] fall_w;
  logic [N_CH-1:0] long_w;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_ch #(
      .CNT_W    (CNT_W),
      .CNT_MAX  (CNT_MAX),
      .LONG_W   (LONG_W),
      .LONG_MAX (LONG_MAX)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .key_i  (bus.key_i[g]),
      .key_o  (key_w[g]),
      .rise_o (rise_w[g]),
      .fall_o (fall_w[g]),
      .long_o (long_w[g])
    );
  end

  assign bus.key_o  = key_w;
  assign bus.rise_o = rise_w;
  assign bus.fall_o = fall_w;
  assign bus.long_o = long_w;

endmodule

// File: tb/tb_multi_debounce.sv
module tb_multi_debounce;

  logic clk;
  logic rst;

  multi_debounce_if #(.N_CH(4)) bus ();

  multi_debounce #(
    .N_CH     (4),
    .CNT_W    (24),
    .CNT_MAX  (24'd3),
    .LONG_W   (16),
    .LONG_MAX (16'd5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp;
  int unsigned n_err;
  logic [3:0]  seen_rise;
  logic [3:0]  seen_fall;
  logic [3:0]  seen_long;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance n rising edges; return at the following falling edge.
  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      seen_rise |= bus.rise_o;
      seen_fall |= bus.fall_o;
      seen_long |= bus.long_o;
    end
  endtask

  task automatic clear_seen();
    seen_rise = '0;
    seen_fall = '0;
    seen_long = '0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    clear_seen();
    rst = 1'b1;
    bus.key_i = 4'b0000;
    @(negedge clk);

    // Reset state
    step(3);
    chk("rst_key",  bus.key_o,  4'b0000);
    chk("rst_rise", bus.rise_o, 4'b0000);
    chk("rst_fall", bus.fall_o, 4'b0000);
    chk("rst_long", bus.long_o, 4'b0000);
    rst = 1'b0;
    step(1);

    // Channel 0 press: key_o after the 7th edge
    bus.key_i = 4'b0001;
    clear_seen();
    step(6);
    chk("ch0_key_e6", bus.key_o, 4'b0000);
    step(1);
    chk("ch0_key_e7",  bus.key_o,  4'b0001);
    chk("ch0_rise_e7", bus.rise_o, 4'b0001);
    step(1);
    chk("ch0_rise_e8", bus.rise_o, 4'b0000);
    chk("ch0_key_e8",  bus.key_o,  4'b0001);

    // Channel 1 glitch of 3 clocks: rejected
    clear_seen();
    bus.key_i = 4'b0011;
    step(3);
    bus.key_i = 4'b0001;
    step(10);
    chk("glitch_key",  bus.key_o,  4'b0001);
    chk("glitch_rise", seen_rise,  4'b0000);
    chk("glitch_fall", seen_fall,  4'b0000);

    // Channel 2 long press (ch0 also hits LONG_MAX meanwhile; mask by step)
    bus.key_i = 4'b0101;
    step(7);
    chk("ch2_rise",    bus.rise_o, 4'b0100);
    chk("ch2_key",     bus.key_o,  4'b0101);
    step(4);
    chk("ch2_long_e11", bus.long_o, 4'b0000);
    step(1);
    chk("ch2_long_e12", bus.long_o, 4'b0100);
    clear_seen();
    step(10);
    chk("ch2_no_second_long", seen_long, 4'b0000);
    chk("ch2_no_second_rise", seen_rise, 4'b0000);

    // Channel 2 release: fall only
    bus.key_i = 4'b0001;
    clear_seen();
    step(6);
    chk("ch2_rel_key_e6", bus.key_o, 4'b0101);
    step(1);
    chk("ch2_fall",     bus.fall_o, 4'b0100);
    chk("ch2_rel_key",  bus.key_o,  4'b0001);
    chk("ch2_rel_long", seen_long,  4'b0000);
    chk("ch2_rel_rise", seen_rise,  4'b0000);
    step(1);
    chk("ch2_fall_e8",  bus.fall_o, 4'b0000);

    // Simultaneous press on channels 1 and 3 after a clean reset
    rst = 1'b1;
    bus.key_i = 4'b0000;
    step(2);
    chk("rst2_key", bus.key_o, 4'b0000);
    rst = 1'b0;
    step(1);
    bus.key_i = 4'b1010;
    clear_seen();
    step(6);
    chk("multi_key_e6", bus.key_o, 4'b0000);
    step(1);
    chk("multi_rise", bus.rise_o, 4'b1010);
    chk("multi_key",  bus.key_o,  4'b1010);
    chk("multi_fall", seen_fall,  4'b0000);

    // Reset mid-count on channel 3: full latency afterwards
    rst = 1'b1;
    bus.key_i = 4'b0000;
    step(2);
    rst = 1'b0;
    bus.key_i = 4'b1000;
    step(4);
    rst = 1'b1;
    step(1);
    chk("midrst_key",  bus.key_o,  4'b0000);
    chk("midrst_rise", bus.rise_o, 4'b0000);
    step(1);
    chk("midrst_key2", bus.key_o,  4'b0000);
    rst = 1'b0;
    step(6);
    chk("postrst_key_e6", bus.key_o, 4'b0000);
    step(1);
    chk("postrst_key_e7",  bus.key_o,  4'b1000);
    chk("postrst_rise_e7", bus.rise_o, 4'b1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
